// File: rtl/s_cell_array.sv
// s_cell_array: CH registered muxes with per-bit AND/OR select gates; latency PIPE enabled edges, en=0 stalls the datapath.
// SCELL_SCAN_EN compiles in the serial shadow/active select config; otherwise the config is fixed at its default.
module s_cell_array #(
  parameter int CH    = 4,
  parameter int SEL_W = 2,
  parameter int PIPE  = 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic [CH*(1<<SEL_W)-1:0]  d,
  input  logic [CH*SEL_W-1:0]       a,
  input  logic [CH*SEL_W-1:0]       b,
  input  logic                      cfg_in,
  input  logic                      cfg_shift,
  input  logic                      cfg_load,
  output logic                      cfg_done,
  output logic [CH-1:0]             out
);
  localparam int NIN = 1 << SEL_W;
  localparam int CW  = CH * SEL_W;

  // Default: select bit 0 of each channel is an AND gate, higher bits are OR gates.
  function automatic logic [CW-1:0] f_def_cfg();
    logic [CW-1:0] v;
    v = '1;
    for (int c = 0; c < CH; c++) v[c*SEL_W] = 1'b0;
    return v;
  endfunction

  localparam logic [CW-1:0] DEF_CFG = f_def_cfg();

  logic [CW-1:0] w_active;

`ifdef SCELL_SCAN_EN
  logic [CW-1:0] r_shadow;
  logic [CW-1:0] r_active;
  logic          r_done;

  // A load samples the shadow before any same-edge shift lands.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_shadow <= DEF_CFG;
      r_active <= DEF_CFG;
      r_done   <= 1'b0;
    end else begin
      r_done <= cfg_load;
      if (cfg_load)  r_active <= r_shadow;
      if (cfg_shift) r_shadow <= (r_shadow << 1) | CW'(cfg_in);
    end
  end

  assign w_active = r_active;
  assign cfg_done = r_done;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{cfg_in, cfg_shift, cfg_load};
  assign w_active     = DEF_CFG;
  assign cfg_done     = 1'b0;
`endif

  logic [CH-1:0] w_bit;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SEL_W-1:0] w_a;
    logic [SEL_W-1:0] w_b;
    logic [SEL_W-1:0] w_cfg;
    logic [SEL_W-1:0] w_sel;
    logic [NIN-1:0]   w_d;

    assign w_a   = a[c*SEL_W +: SEL_W];
    assign w_b   = b[c*SEL_W +: SEL_W];
    assign w_cfg = w_active[c*SEL_W +: SEL_W];
    assign w_d   = d[c*NIN +: NIN];
    assign w_sel = (w_a & w_b & ~w_cfg) | ((w_a | w_b) & w_cfg);
    assign w_bit[c] = w_d[w_sel];
  end

  if (PIPE == 2) begin : g_pipe2
    logic [CH-1:0] r_stage;
    logic [CH-1:0] r_out;

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        r_stage <= '0;
        r_out   <= '0;
      end else if (en) begin
        r_stage <= w_bit;
        r_out   <= r_stage;
      end
    end

    assign out = r_out;
  end else begin : g_pipe1
    logic [CH-1:0] r_out;

    always_ff @(posedge clk or negedge clr) begin
      if (!clr)    r_out <= '0;
      else if (en) r_out <= w_bit;
    end

    assign out = r_out;
  end

endmodule

// File: tb/tb_s_cell_array.sv
// Bench for s_cell_array: PIPE=1 and PIPE=2 instances share stimulus; a reference model feeds a scoreboard queue.
`timescale 1ns/1ps
module tb_s_cell_array;
  localparam int CH    = 4;
  localparam int SEL_W = 2;
  localparam int NIN   = 4;
  localparam int CW    = CH * SEL_W;
  localparam int DW    = CH * NIN;
  localparam logic [CW-1:0] DEF_CFG = 8'hAA;
`ifdef SCELL_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic [DW-1:0] d;
  logic [CW-1:0] a;
  logic [CW-1:0] b;
  logic          cfg_in;
  logic          cfg_shift;
  logic          cfg_load;
  logic          done1;
  logic          done2;
  logic [CH-1:0] out1;
  logic [CH-1:0] out2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [CH-1:0] o1;
    logic [CH-1:0] o2;
    logic          dn;
  } exp_t;

  exp_t q_exp[$];
  exp_t sb_e;

  logic [CW-1:0] m_shadow;
  logic [CW-1:0] m_active;
  logic [CH-1:0] m_stage;
  logic [CH-1:0] m_out1;
  logic [CH-1:0] m_out2;
  logic          m_done;

  always #5 clk = ~clk;

  s_cell_array #(.CH(CH), .SEL_W(SEL_W), .PIPE(1)) u_dut1 (
    .clk(clk), .clr(clr), .en(en), .d(d), .a(a), .b(b),
    .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
    .cfg_done(done1), .out(out1)
  );

  s_cell_array #(.CH(CH), .SEL_W(SEL_W), .PIPE(2)) u_dut2 (
    .clk(clk), .clr(clr), .en(en), .d(d), .a(a), .b(b),
    .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
    .cfg_done(done2), .out(out2)
  );

  function automatic logic [CH-1:0] f_pick(input logic [CW-1:0] cfg, input logic [DW-1:0] dd,
                                           input logic [CW-1:0] aa, input logic [CW-1:0] bb);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int  s;
      logic g;
      s = 0;
      for (int k = 0; k < SEL_W; k++) begin
        if (cfg[c*SEL_W+k]) g = aa[c*SEL_W+k] | bb[c*SEL_W+k];
        else                g = aa[c*SEL_W+k] & bb[c*SEL_W+k];
        s = s | (int'(g) << k);
      end
      r[c] = dd[c*NIN+s];
    end
    return r;
  endfunction

  task automatic m_reset();
    m_shadow = DEF_CFG;
    m_active = DEF_CFG;
    m_stage  = '0;
    m_out1   = '0;
    m_out2   = '0;
    m_done   = 1'b0;
    q_exp.delete();
  endtask

  // Scoreboard: pops the expectation pushed for the edge just taken.
  always @(posedge clk) begin
    #1;
    if (q_exp.size() > 0) begin
      sb_e = q_exp.pop_front();
      n_tests++;
      if (out1 !== sb_e.o1) begin
        n_fail++;
        $display("FAIL sb_out1 got=%b want=%b t=%0t", out1, sb_e.o1, $time);
      end
      n_tests++;
      if (out2 !== sb_e.o2) begin
        n_fail++;
        $display("FAIL sb_out2 got=%b want=%b t=%0t", out2, sb_e.o2, $time);
      end
      n_tests++;
      if (done1 !== sb_e.dn || done2 !== sb_e.dn) begin
        n_fail++;
        $display("FAIL sb_done got=%b/%b want=%b t=%0t", done1, done2, sb_e.dn, $time);
      end
    end
  end

  task automatic step(input logic i_en, input logic [DW-1:0] i_d, input logic [CW-1:0] i_a,
                      input logic [CW-1:0] i_b, input logic i_in, input logic i_sh, input logic i_ld);
    logic [CH-1:0] pick;
    en = i_en; d = i_d; a = i_a; b = i_b;
    cfg_in = i_in; cfg_shift = i_sh; cfg_load = i_ld;
    pick = f_pick(m_active, i_d, i_a, i_b);
    if (i_en) begin
      m_out1  = pick;
      m_out2  = m_stage;
      m_stage = pick;
    end
`ifdef SCELL_SCAN_EN
    m_done = i_ld;
    if (i_ld) m_active = m_shadow;
    if (i_sh) m_shadow = {m_shadow[CW-2:0], i_in};
`else
    m_done = 1'b0;
`endif
    q_exp.push_back('{o1: m_out1, o2: m_out2, dn: m_done});
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    n_tests++;
    if (out1 !== '0 || out2 !== '0 || done1 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got=%b/%b/%b%b want=0", out1, out2, done1, done2);
    end
    m_reset();
    en = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0; cfg_in = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b0; d = '0; a = '0; b = '0;
    cfg_in = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0;
    #3;
    clr = 1'b0;
    #1;
    n_tests++;
    if (out1 !== '0 || out2 !== '0) begin
      n_fail++;
      $display("FAIL reset_out got=%b/%b want=0/0", out1, out2);
    end
    n_tests++;
    if (done1 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got=%b%b want=00", done1, done2);
    end
    m_reset();
    @(posedge clk);
    #2;
    clr = 1'b1;
  endtask

  task automatic test_default_decode();
    step(1'b1, 16'h0002, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out1 !== 4'b0001) begin
      n_fail++;
      $display("FAIL default_decode out1 got=%b want=0001", out1);
    end
    step(1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out2 !== 4'b0001) begin
      n_fail++;
      $display("FAIL default_decode out2 got=%b want=0001", out2);
    end
  endtask

  task automatic test_pipe2_enable();
    step(1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out2 !== 4'h0 || out1 !== 4'hF) begin
      n_fail++;
      $display("FAIL pipe_first_edge got=%h/%h want=F/0", out1, out2);
    end
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out2 !== 4'h0 || out1 !== 4'hF) begin
      n_fail++;
      $display("FAIL pipe_hold got=%h/%h want=F/0", out1, out2);
    end
    step(1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out2 !== 4'hF || out1 !== 4'h0) begin
      n_fail++;
      $display("FAIL pipe_second_edge got=%h/%h want=0/F", out1, out2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom), CW'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_scan_load();
    do_reset();
    for (int i = 0; i < CW; i++) step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (done1 !== SCAN) begin
      n_fail++;
      $display("FAIL scan_done_pulse got=%b want=%b", done1, SCAN);
    end
    step(1'b1, 16'h0002, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_done_width got=%b want=0", done1);
    end
    n_tests++;
    if (out1[0] !== SCAN) begin
      n_fail++;
      $display("FAIL scan_or_decode got=%b want=%b", out1[0], SCAN);
    end
  endtask

  task automatic test_shift_load_same();
    do_reset();
    for (int i = 0; i < CW - 1; i++) step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h2222, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out1 !== (SCAN ? 4'b0001 : 4'b0000)) begin
      n_fail++;
      $display("FAIL same_cycle_active got=%b want=%b", out1, (SCAN ? 4'b0001 : 4'b0000));
    end
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h4444, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out1 !== (SCAN ? 4'b0001 : 4'b1111)) begin
      n_fail++;
      $display("FAIL same_cycle_shadow got=%b want=%b", out1, (SCAN ? 4'b0001 : 4'b1111));
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (done1 !== SCAN) begin
      n_fail++;
      $display("FAIL b2b_done_first got=%b want=%b", done1, SCAN);
    end
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (done1 !== SCAN) begin
      n_fail++;
      $display("FAIL b2b_done_second got=%b want=%b", done1, SCAN);
    end
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_end got=%b want=0", done1);
    end
  endtask

  task automatic test_reset_abort();
    step(1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    cfg_load = 1'b1; cfg_shift = 1'b1; cfg_in = 1'b1; en = 1'b1;
    #1;
    clr = 1'b0;
    #1;
    n_tests++;
    if (out1 !== '0 || out2 !== '0) begin
      n_fail++;
      $display("FAIL abort_out got=%b/%b want=0/0", out1, out2);
    end
    m_reset();
    @(posedge clk);
    #2;
    cfg_load = 1'b0; cfg_shift = 1'b0; en = 1'b0;
    clr = 1'b1;
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (done1 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%b%b want=00", done1, done2);
    end
    step(1'b1, 16'h4444, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out1 !== 4'b1111) begin
      n_fail++;
      $display("FAIL abort_default_cfg got=%b want=1111", out1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_decode();
    test_pipe2_enable();
    test_random();
    test_scan_load();
    test_shift_load_same();
    test_back_to_back();
    test_reset_abort();
    test_random();
    @(posedge clk);
    #3;
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d want=0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
